// File: rtl/pipelined_cla_adder_if.sv
// Handshake and data bundle for pipelined_cla_adder: operand beat in, result beat out.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// group carries registered between stages, flags formed in the last stage.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int NG = WIDTH / BLOCK;

    // Registered state of each stage; entry NG-1 drives the outputs.
    logic             v_q [NG];
    logic             c_q [NG];
    logic [WIDTH-1:0] a_q [NG];
    logic [WIDTH-1:0] b_q [NG];
    logic [WIDTH-1:0] s_q [NG];
    logic             ovf_q;
    logic             zero_q;

    logic             v_d [NG];
    logic             c_d [NG];
    logic [WIDTH-1:0] a_d [NG];
    logic [WIDTH-1:0] b_d [NG];
    logic [WIDTH-1:0] s_d [NG];
    logic             ovf_d;
    logic             zero_d;

    // Stage inputs: entry 0 is the conditioned operand beat, entry k the register of stage k-1.
    logic             v_x [NG];
    logic             c_x [NG];
    logic [WIDTH-1:0] a_x [NG];
    logic [WIDTH-1:0] b_x [NG];
    logic [WIDTH-1:0] s_x [NG];

    logic stall;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    always_comb begin
        v_x[0] = bus.in_valid;
        a_x[0] = bus.a;
        b_x[0] = bus.sub ? ~bus.b : bus.b;
        c_x[0] = bus.carry_in ^ bus.sub;
        s_x[0] = '0;
        for (int k = 1; k < NG; k++) begin
            v_x[k] = v_q[k-1];
            a_x[k] = a_q[k-1];
            b_x[k] = b_q[k-1];
            c_x[k] = c_q[k-1];
            s_x[k] = s_q[k-1];
        end
    end

    always_comb begin
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        logic             prop;
        g      = '0;
        p      = '0;
        c      = '0;
        term   = 1'b0;
        prop   = 1'b0;
        ovf_d  = 1'b0;
        zero_d = 1'b0;
        for (int k = 0; k < NG; k++) begin
            g    = a_x[k][k*BLOCK +: BLOCK] & b_x[k][k*BLOCK +: BLOCK];
            p    = a_x[k][k*BLOCK +: BLOCK] ^ b_x[k][k*BLOCK +: BLOCK];
            c[0] = c_x[k];
            // Each carry is a flat sum of products of g/p and the group carry-in, not a chain.
            for (int i = 0; i < BLOCK; i++) begin
                term = g[i];
                prop = p[i];
                for (int j = i - 1; j >= 0; j--) begin
                    term = term | (prop & g[j]);
                    prop = prop & p[j];
                end
                c[i+1] = term | (prop & c_x[k]);
            end
            v_d[k]                     = v_x[k];
            a_d[k]                     = a_x[k];
            b_d[k]                     = b_x[k];
            c_d[k]                     = c[BLOCK];
            s_d[k]                     = s_x[k];
            s_d[k][k*BLOCK +: BLOCK]   = p ^ c[BLOCK-1:0];
            if (k == NG - 1) begin
                ovf_d  = c[BLOCK] ^ c[BLOCK-1];
                zero_d = (s_d[k] == '0);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // previous stage's old value on the same edge; blocking here would collapse the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset as well as valids because the last stage drives
            // sum and the flags directly, and those must read 0 while reset is applied.
            for (int k = 0; k < NG; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < NG; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.out_valid = v_q[NG-1];
    assign bus.sum       = s_q[NG-1];
    assign bus.carry_out = c_q[NG-1];
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, BLOCK=4): directed cases,
// backpressure, mid-flight reset and randomized traffic against an arithmetic model.
module tb_pipelined_cla_adder;
    localparam int WIDTH = 16;
    localparam int BLOCK = 4;
    localparam int NG    = WIDTH / BLOCK;

    typedef struct packed {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   recv  = 0;
    exp_t q[$];

    pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed and unsigned integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        int   sa, sb, ua, ub, sr, ur;
        exp_t e;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        if (sub) begin
            sr   = sa - sb - int'(cin);
            ur   = ua - ub - int'(cin);
            e.co = (ur >= 0);
        end else begin
            sr   = sa + sb + int'(cin);
            ur   = ua + ub + int'(cin);
            e.co = (ur > 65535);
        end
        e.ov  = (sr > 32767) || (sr < -32768);
        e.sum = ur[15:0];
        e.z   = (e.sum == 16'h0);
        return e;
    endfunction

    // Scoreboard: results checked in order at transfer, accepted beats modelled at accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    check("result", {bus.sum, bus.carry_out, bus.overflow, bus.zero}, q.pop_front());
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.carry_in, bus.sub));
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        bus.sub      = sub;
    endtask

    // One isolated beat: checks latency, the stated result and a one-cycle out_valid pulse.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub, input logic [15:0] esum,
                           input logic eco, input logic eov, input logic ez);
        int lat;
        @(posedge clk); #1;
        drive(a, b, cin, sub);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, NG);
        check({tag, "_sum"}, bus.sum, esum);
        check({tag, "_flags"}, {bus.carry_out, bus.overflow, bus.zero}, {eco, eov, ez});
        @(posedge clk); #1;
        check({tag, "_pulse"}, bus.out_valid, 1'b0);
    endtask

    logic        acc;
    logic        stalling;
    logic        stall_done;
    int          scnt;
    int          idx;
    int          recv0;
    logic [18:0] held;
    logic [15:0] ra, rb;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        #23;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_outputs", {bus.sum, bus.carry_out, bus.overflow, bus.zero}, 19'h0);
        check("reset_in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;

        run_one("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_one("carry",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_one("ovf_sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_one("borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_one("borrow_c", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);

        // Backpressure: six back-to-back beats, out_ready low for three edges at first result.
        recv0      = recv;
        idx        = 0;
        stalling   = 1'b0;
        stall_done = 1'b0;
        scnt       = 0;
        @(posedge clk); #1;
        drive(16'(idx + 1), 16'(idx + 1), 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && !(idx == 6 && q.size() == 0); cyc++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (stalling) check("stall_in_ready", bus.in_ready, 1'b0);
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 6) drive(16'(idx + 1), 16'(idx + 1), 1'b0, 1'b0);
            else bus.in_valid = 1'b0;
            if (stalling) begin
                scnt++;
                check("stall_valid", bus.out_valid, 1'b1);
                check("stall_hold", {bus.sum, bus.carry_out, bus.overflow, bus.zero}, held);
                if (scnt == 3) begin
                    bus.out_ready = 1'b1;
                    stalling      = 1'b0;
                end
            end else if (!stall_done && bus.out_valid) begin
                stalling      = 1'b1;
                stall_done    = 1'b1;
                bus.out_ready = 1'b0;
                held          = {bus.sum, bus.carry_out, bus.overflow, bus.zero};
                scnt          = 0;
            end
        end
        bus.in_valid = 1'b0;
        check("bp_stall_seen", stall_done, 1'b1);
        check("bp_count", recv - recv0, 6);

        // Reset mid-flight: two beats in the pipe, reset pulsed between edges.
        @(posedge clk); #1;
        drive(16'h0011, 16'h0022, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(16'h0033, 16'h0044, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.sum, 16'h0);
        @(posedge clk); #3;
        rst = 1'b0;
        run_one("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("no_stale", bus.out_valid, 1'b0);

        // Randomized traffic with random backpressure and corner operands.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 5))
                0: ra = 16'hFFFF;
                1: ra = 16'h8000;
                2: ra = 16'h7FFF;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 4) == 0) ? 16'h0001 : 16'($urandom);
            drive(ra, rb, 1'($urandom), 1'($urandom));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
